counterup16_ctrl_async_resetn: RTL and testbench

- 16-bit up counter, the opposite direction of the team's 16-bit free-running down counter.
- Adds enable, synchronous clear, parallel load, wrap-or-saturate mode, a compare-match output, a terminal-count pulse and a sticky overflow flag.
- Used as a micro-benchmark register block and as a general event/timebase counter.
- Single clock domain; no handshake with other blocks.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_prescaler.sv | 29 ++
 rtl/counterup16_ctrl_async_resetn.sv | 99 +++++++++
 tb/tb_counterup16_ctrl_async_resetn.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the up-counter block: default width,
// all-ones helper and the terminal-count behaviour enumeration.
package counter_pkg;

    localparam int unsigned COUNTER_WIDTH = 16;

    typedef enum logic {
        MODE_WRAP     = 1'b0,
        MODE_SATURATE = 1'b1
    } ovf_mode_e;

    // Widths of 64 and above collapse to all-ones through the shift-out
    function automatic logic [63:0] all_ones(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: counts enabled cycles 0..PRESCALE-1 and flags the last one
// so the parent counter steps once per PRESCALE enabled cycles.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clock0,
    input  logic reset,
    input  logic i_en,
    input  logic i_clear,
    output logic o_step
);

    localparam logic [7:0] C_LAST = 8'(PRESCALE - 1);

    logic [7:0] r_pcnt;

    assign o_step = (r_pcnt == C_LAST);

    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            r_pcnt <= '0;
        end else if (i_clear) begin
            r_pcnt <= '0;
        end else if (i_en) begin
            r_pcnt <= o_step ? 8'd0 : r_pcnt + 8'd1;
        end
    end

endmodule

// File: rtl/counterup16_ctrl_async_resetn.sv
// Up counter with enable, clear, load, wrap/saturate, compare match, tc pulse
// and sticky overflow. Define COUNTERUP16_PRESCALE_EN to divide the enable.
module counterup16_ctrl_async_resetn
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = COUNTER_WIDTH,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             ovf_ack,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             match,
    output logic             ovf
);

    localparam logic [63:0]      C_ALL    = all_ones(WIDTH);
    localparam logic [WIDTH-1:0] C_MAX    = C_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_MAX_M1 = C_MAX - C_ONE;
    localparam ovf_mode_e        C_MODE   = (SATURATE != 0) ? MODE_SATURATE : MODE_WRAP;

    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
        $error("PRESCALE must be in 1..256");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             w_strobe;
    logic             w_step;
    logic             w_overflow;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;

`ifdef COUNTERUP16_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock0  (clock0),
        .reset   (reset),
        .i_en    (en),
        .i_clear (clr | load),
        .o_step  (w_strobe)
    );
`else
    assign w_strobe = 1'b1;
`endif

    assign w_step     = en & w_strobe;
    // Overflow only counts when a real step is attempted at all-ones
    assign w_overflow = !clr && !load && w_step && (r_count == C_MAX);

    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        if (clr) begin
            w_count_nxt = '0;
        end else if (load) begin
            w_count_nxt = load_val;
        end else if (w_step) begin
            if (r_count == C_MAX) begin
                w_count_nxt = (C_MODE == MODE_SATURATE) ? C_MAX : '0;
            end else begin
                w_count_nxt = r_count + C_ONE;
                w_tc_nxt    = (r_count == C_MAX_M1);
            end
        end
    end

    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            if (w_overflow) begin
                r_ovf <= 1'b1;
            end else if (ovf_ack) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;
    assign match = (r_count == cmp_val);

endmodule

// File: tb/tb_counterup16_ctrl_async_resetn.sv
// Bench for the up counter: wrap and saturate instances share stimulus and are
// compared every edge against an arithmetic reference model.
module tb_counterup16_ctrl_async_resetn;

    localparam int PRE  = 4;
    localparam int MAXV = 65535;

    logic        clock0 = 1'b0;
    logic        reset  = 1'b0;
    logic        en = 1'b0, clr = 1'b0, load = 1'b0, ovf_ack = 1'b0;
    logic [15:0] load_val = 16'h0, cmp_val = 16'h0;
    logic [15:0] count_w, count_s;
    logic        tc_w, tc_s, match_w, match_s, ovf_w, ovf_s;

    int vectors = 0;
    int errors  = 0;

    int m_cnt [2];
    bit m_tc  [2];
    bit m_ovf [2];
    int m_pre;

    always #5 clock0 = ~clock0;

    counterup16_ctrl_async_resetn #(.WIDTH(16), .SATURATE(0), .PRESCALE(PRE)) dut_w (
        .clock0(clock0), .reset(reset), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .cmp_val(cmp_val), .ovf_ack(ovf_ack),
        .count(count_w), .tc(tc_w), .match(match_w), .ovf(ovf_w)
    );

    counterup16_ctrl_async_resetn #(.WIDTH(16), .SATURATE(1), .PRESCALE(PRE)) dut_s (
        .clock0(clock0), .reset(reset), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .cmp_val(cmp_val), .ovf_ack(ovf_ack),
        .count(count_s), .tc(tc_s), .match(match_s), .ovf(ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_cnt[s] = 0;
            m_tc[s]  = 1'b0;
            m_ovf[s] = 1'b0;
        end
        m_pre = 0;
    endtask

    task automatic model_edge();
        bit strobe;
`ifdef COUNTERUP16_PRESCALE_EN
        strobe = (m_pre == PRE - 1);
        if (clr || load) m_pre = 0;
        else if (en)     m_pre = strobe ? 0 : m_pre + 1;
`else
        strobe = 1'b1;
`endif
        for (int s = 0; s < 2; s++) begin
            bit ovf_evt;
            ovf_evt  = 1'b0;
            m_tc[s]  = 1'b0;
            if (clr) begin
                m_cnt[s] = 0;
            end else if (load) begin
                m_cnt[s] = int'(load_val);
            end else if (en && strobe) begin
                if (m_cnt[s] == MAXV) begin
                    ovf_evt  = 1'b1;
                    m_cnt[s] = (s == 1) ? MAXV : 0;
                end else begin
                    m_cnt[s] = m_cnt[s] + 1;
                    m_tc[s]  = (m_cnt[s] == MAXV);
                end
            end
            if (ovf_evt)      m_ovf[s] = 1'b1;
            else if (ovf_ack) m_ovf[s] = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_wrap_count"}, {16'h0, count_w}, m_cnt[0]);
        chk({tag, "_wrap_tc"},    {31'h0, tc_w},    {31'h0, m_tc[0]});
        chk({tag, "_wrap_ovf"},   {31'h0, ovf_w},   {31'h0, m_ovf[0]});
        chk({tag, "_wrap_match"}, {31'h0, match_w}, {31'h0, (m_cnt[0] == int'(cmp_val))});
        chk({tag, "_sat_count"},  {16'h0, count_s}, m_cnt[1]);
        chk({tag, "_sat_tc"},     {31'h0, tc_s},    {31'h0, m_tc[1]});
        chk({tag, "_sat_ovf"},    {31'h0, ovf_s},   {31'h0, m_ovf[1]});
        chk({tag, "_sat_match"},  {31'h0, match_s}, {31'h0, (m_cnt[1] == int'(cmp_val))});
    endtask

    task automatic tick(input string tag);
        @(posedge clock0);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        @(negedge clock0);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        compare_all("in_reset");
        cmp_val = 16'h0005;
        #1;
        compare_all("in_reset_cmp");
        cmp_val = 16'h0000;

        @(negedge clock0);
        reset = 1'b1;
        en    = 1'b1;
        for (int i = 0; i < 5; i++) tick("count_up");
`ifndef COUNTERUP16_PRESCALE_EN
        chk("five_steps", {16'h0, count_w}, 32'd5);
`endif
        async_reset_pulse("async_rst");

        load = 1'b1; load_val = 16'hFFFD;
        tick("load_fffd");
        load = 1'b0;
        for (int i = 0; i < 10; i++) tick("near_max");
        ovf_ack = 1'b1;
        tick("ack_while_en");
        ovf_ack = 1'b0;
        for (int i = 0; i < 4; i++) tick("after_ack");
        en = 1'b0; ovf_ack = 1'b1;
        tick("ack_idle");
        ovf_ack = 1'b0;

        load = 1'b1; load_val = 16'h1234;
        tick("load_1234");
        clr = 1'b1; en = 1'b1;
        tick("clr_beats_load");
        clr = 1'b0; load_val = 16'h00AA;
        tick("load_00aa");
        load = 1'b0;

        load = 1'b1; load_val = 16'hFFFF; en = 1'b0;
        tick("load_ffff_no_tc");
        load = 1'b0;

        clr = 1'b1; cmp_val = 16'h0003;
        tick("clr_for_cmp");
        clr = 1'b0; en = 1'b1;
        for (int i = 0; i < 16; i++) tick("cmp_walk");

        clr = 1'b1;
        tick("clr_for_gap");
        clr = 1'b0;
        for (int i = 0; i < 3; i++) tick("gap_pre");
        en = 1'b0;
        for (int i = 0; i < 2; i++) tick("gap_hold");
        en = 1'b1;
        for (int i = 0; i < 8; i++) tick("gap_post");

        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r       = $urandom;
            en      = (r[1:0] != 2'b00);
            clr     = (r[5:2] == 4'h0);
            load    = (r[9:6] == 4'h0);
            ovf_ack = (r[12:10] == 3'b000);
            case (r[15:13])
                3'd0:    load_val = 16'hFFFF;
                3'd1:    load_val = 16'hFFFE;
                3'd2:    load_val = 16'hFFFC;
                default: load_val = 16'($urandom);
            endcase
            cmp_val = (r[16]) ? count_w + 16'(r[18:17]) : 16'($urandom_range(0, 7));
            if (r[24:19] == 6'd0) async_reset_pulse("rand_rst");
            else                  tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
